// File: rtl/sprite_palette_lut_if.sv
// rtl/sprite_palette_lut_if.sv - palette write, lookup, fade and flash signal bundle
interface sprite_palette_lut_if #(
  parameter int INDEX_W   = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 2
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                wr_en;
  logic [BANK_W-1:0]   wr_bank;
  logic [INDEX_W-1:0]  wr_index;
  logic [3*CH_W-1:0]   wr_rgb;
  logic                in_valid;
  logic [BANK_W-1:0]   in_bank;
  logic [INDEX_W-1:0]  in_index;
  logic                fade_we;
  logic [3:0]          fade_level;
  logic                flash_start;
  logic                frame_tick;
  logic                out_valid;
  logic [3*CH_W-1:0]   out_rgb;
  logic                out_transparent;
  logic                flashing;

  modport master (
    output wr_en, wr_bank, wr_index, wr_rgb,
    output in_valid, in_bank, in_index,
    output fade_we, fade_level, flash_start, frame_tick,
    input  out_valid, out_rgb, out_transparent, flashing
  );

  modport slave (
    input  wr_en, wr_bank, wr_index, wr_rgb,
    input  in_valid, in_bank, in_index,
    input  fade_we, fade_level, flash_start, frame_tick,
    output out_valid, out_rgb, out_transparent, flashing
  );
endinterface

// File: rtl/sprite_palette_lut.sv
// rtl/sprite_palette_lut.sv - multi-bank writable palette with transparency, fade and hit flash
module sprite_palette_lut #(
  parameter int INDEX_W      = 4,
  parameter int CH_W         = 4,
  parameter int NUM_BANKS    = 2,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sprite_palette_lut_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam int RGB_W   = 3 * CH_W;
  localparam int CNT_W   = $clog2(FLASH_FRAMES + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLASH = 1'b1;

  logic [RGB_W-1:0] mem_q [NUM_BANKS][ENTRIES];
  logic [RGB_W-1:0] mem_d [NUM_BANKS][ENTRIES];

  logic             s1_valid_q, s1_valid_d;
  logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
  logic             s1_transp_q, s1_transp_d;

  logic             out_valid_q, out_valid_d;
  logic [RGB_W-1:0] out_rgb_q, out_rgb_d;
  logic             out_transp_q, out_transp_d;

  logic [3:0]       fade_q, fade_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Product fits in CH_W+4 bits since (L+1) <= 16; keeping the top CH_W bits is the >>4.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c, input logic [3:0] l);
    logic [CH_W+3:0] prod;
    prod = {4'b0, c} * (CH_W+4)'({1'b0, l} + 5'd1);
    return CH_W'(prod >> 4);
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (bus.wr_en && (int'(bus.wr_bank) < NUM_BANKS))
      mem_d[bus.wr_bank][bus.wr_index] = bus.wr_rgb;
  end

  // Stage 1 reads mem_q, so a same-cycle write is not yet visible.
  always_comb begin
    s1_valid_d  = bus.in_valid;
    s1_rgb_d    = s1_rgb_q;
    s1_transp_d = s1_transp_q;
    if (bus.in_valid) begin
      s1_rgb_d    = (int'(bus.in_bank) < NUM_BANKS) ? mem_q[bus.in_bank][bus.in_index] : '0;
      s1_transp_d = (int'(bus.in_index) == TRANSP_IDX);
    end
  end

  always_comb begin
    out_valid_d  = s1_valid_q;
    out_rgb_d    = out_rgb_q;
    out_transp_d = out_transp_q;
    if (s1_valid_q) begin
      out_transp_d = s1_transp_q;
      if (s1_transp_q)
        out_rgb_d = '0;
      else if (state_q == FLASH)
        out_rgb_d = '1;
      else
        out_rgb_d = {fade_ch(s1_rgb_q[3*CH_W-1:2*CH_W], fade_q),
                     fade_ch(s1_rgb_q[2*CH_W-1:CH_W], fade_q),
                     fade_ch(s1_rgb_q[CH_W-1:0], fade_q)};
    end
  end

  always_comb begin
    fade_d = bus.fade_we ? bus.fade_level : fade_q;
  end

  // flash_start wins over a simultaneous frame_tick in either state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.flash_start) begin
          state_d = FLASH;
          cnt_d   = '0;
        end
      end
      default: begin
        if (bus.flash_start) begin
          cnt_d = '0;
        end else if (bus.frame_tick) begin
          if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < ENTRIES; i++)
          mem_q[b][i] <= '0;
      s1_valid_q   <= 1'b0;
      s1_rgb_q     <= '0;
      s1_transp_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_rgb_q    <= '0;
      out_transp_q <= 1'b0;
      fade_q       <= 4'hF;
      state_q      <= IDLE;
      cnt_q        <= '0;
    end else begin
      mem_q        <= mem_d;
      s1_valid_q   <= s1_valid_d;
      s1_rgb_q     <= s1_rgb_d;
      s1_transp_q  <= s1_transp_d;
      out_valid_q  <= out_valid_d;
      out_rgb_q    <= out_rgb_d;
      out_transp_q <= out_transp_d;
      fade_q       <= fade_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_rgb         = out_rgb_q;
  assign bus.out_transparent = out_transp_q;
  assign bus.flashing        = (state_q == FLASH);
endmodule

// File: tb/tb_sprite_palette_lut.sv
// tb/tb_sprite_palette_lut.sv - scoreboard bench for sprite_palette_lut
module tb_sprite_palette_lut;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  sprite_palette_lut_if bus ();

  sprite_palette_lut dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] rgb;
    logic        tr;
    int          at;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0]  fade;
    logic        bank;
    logic [3:0]  idx;
    logic [11:0] rgb;
    logic        tr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_rgb", 32'(bus.out_rgb), 32'(e.rgb));
        check("out_transparent", 32'(bus.out_transparent), 32'(e.tr));
        check("latency_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic push(input logic [11:0] rgb, input logic tr);
    exp_t e;
    e.rgb = rgb;
    e.tr  = tr;
    e.at  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic lookup(input logic bank, input logic [3:0] idx, input logic [11:0] rgb, input logic tr);
    bus.in_valid = 1'b1;
    bus.in_bank  = bank;
    bus.in_index = idx;
    push(rgb, tr);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic write_entry(input logic bank, input logic [3:0] idx, input logic [11:0] rgb);
    bus.wr_en    = 1'b1;
    bus.wr_bank  = bank;
    bus.wr_index = idx;
    bus.wr_rgb   = rgb;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic set_fade(input logic [3:0] l);
    bus.fade_we    = 1'b1;
    bus.fade_level = l;
    @(negedge clk);
    bus.fade_we = 1'b0;
  endtask

  task automatic pulse(input logic start, input logic tick);
    bus.flash_start = start;
    bus.frame_tick  = tick;
    @(negedge clk);
    bus.flash_start = 1'b0;
    bus.frame_tick  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1);
  endtask

  vec_t vecs[6];

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_index = '0; bus.wr_rgb = '0;
    bus.in_valid = 1'b0; bus.in_bank = '0; bus.in_index = '0;
    bus.fade_we = 1'b0; bus.fade_level = '0;
    bus.flash_start = 1'b0; bus.frame_tick = 1'b0;

    vecs[0] = '{4'd7,  1'b0, 4'd9, 12'h742, 1'b0};
    vecs[1] = '{4'd0,  1'b0, 4'd9, 12'h000, 1'b0};
    vecs[2] = '{4'd15, 1'b0, 4'd9, 12'hF84, 1'b0};
    vecs[3] = '{4'd7,  1'b1, 4'd3, 12'h741, 1'b0};
    vecs[4] = '{4'd3,  1'b0, 4'd0, 12'h000, 1'b1};
    vecs[5] = '{4'd15, 1'b0, 4'd3, 12'hC32, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_out_rgb", 32'(bus.out_rgb), 0);
    check("reset_out_transparent", 32'(bus.out_transparent), 0);
    check("reset_flashing", 32'(bus.flashing), 0);
    rst_n = 1'b1;
    @(negedge clk);

    lookup(1'b0, 4'd5, 12'h000, 1'b0);
    lookup(1'b0, 4'd0, 12'h000, 1'b1);
    drain();

    write_entry(1'b1, 4'd3, 12'hF93);
    write_entry(1'b0, 4'd3, 12'hC32);
    write_entry(1'b0, 4'd9, 12'hF84);
    lookup(1'b1, 4'd3, 12'hF93, 1'b0);
    lookup(1'b0, 4'd3, 12'hC32, 1'b0);
    drain();

    // Collision: write and lookup of [0][7] in the same cycle returns the old value.
    bus.wr_en = 1'b1; bus.wr_bank = 1'b0; bus.wr_index = 4'd7; bus.wr_rgb = 12'hABC;
    lookup(1'b0, 4'd7, 12'h000, 1'b0);
    bus.wr_en = 1'b0;
    lookup(1'b0, 4'd7, 12'hABC, 1'b0);
    drain();

    foreach (vecs[i]) begin
      set_fade(vecs[i].fade);
      lookup(vecs[i].bank, vecs[i].idx, vecs[i].rgb, vecs[i].tr);
      drain();
    end

    pulse(1'b1, 1'b0);
    check("flash_on", 32'(bus.flashing), 1);
    lookup(1'b0, 4'd3, 12'hFFF, 1'b0);
    lookup(1'b0, 4'd0, 12'h000, 1'b1);
    drain();
    ticks(3);
    check("flash_after_3_ticks", 32'(bus.flashing), 1);
    ticks(1);
    check("flash_after_4_ticks", 32'(bus.flashing), 0);

    pulse(1'b1, 1'b0);
    ticks(2);
    pulse(1'b1, 1'b0);
    ticks(3);
    check("restart_after_5_ticks", 32'(bus.flashing), 1);
    ticks(1);
    check("restart_after_6_ticks", 32'(bus.flashing), 0);

    pulse(1'b1, 1'b1);
    ticks(3);
    check("start_tick_idle_3", 32'(bus.flashing), 1);
    ticks(1);
    check("start_tick_idle_4", 32'(bus.flashing), 0);

    pulse(1'b1, 1'b0);
    ticks(1);
    pulse(1'b1, 1'b1);
    ticks(3);
    check("start_tick_flash_3", 32'(bus.flashing), 1);
    ticks(1);
    check("start_tick_flash_4", 32'(bus.flashing), 0);

    // Reset with two requests in flight, flash active and fade reduced.
    set_fade(4'd7);
    pulse(1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_bank = 1'b0; bus.in_index = 4'd3;
    @(negedge clk);
    bus.in_index = 4'd9;
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", 32'(bus.out_valid), 0);
    end
    check("post_reset_flashing", 32'(bus.flashing), 0);
    lookup(1'b0, 4'd3, 12'h000, 1'b0);
    lookup(1'b1, 4'd3, 12'h000, 1'b0);
    drain();
    write_entry(1'b0, 4'd9, 12'hF84);
    lookup(1'b0, 4'd9, 12'hF84, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
